alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
// - Shares the single 8-bit ALU between N_REQ requesters (e.g. execute stage, branch unit).
// - Per-requester valid/ready request and response channels; one op in flight at a time.
// - Round-robin grant; registers operands into the ALU and its result/zero flag out of it.
// - Sits between requesters and the combinational alu (instruction/input1/input2 -> result/zero).
// PARAMETERS
// - N_REQ   2  number of requesters (2..4)
// - WIDTH   8  operand/result width; must match ALU datapath
// - OP_W    3  ALU opcode width
// PORTS
// - clk             in   1            single clock; all state updates on posedge
// - reset_n         in   1            synchronous, active-low reset
// - req_valid       in   N_REQ        request i presents op/operands
// - req_ready       out  N_REQ        request i accepted this cycle (one-hot or zero)
// - req_op          in   N_REQ*OP_W   opcode, requester i at [i*OP_W +: OP_W]
// - req_a           in   N_REQ*WIDTH  operand 1, requester i at [i*WIDTH +: WIDTH]
// - req_b           in   N_REQ*WIDTH  operand 2 (shift amount for RSL)
// - rsp_valid       out  N_REQ        response for requester i available (one-hot or zero)
// - rsp_ready       in   N_REQ        requester i consumes the response
// - rsp_result      out  WIDTH        registered ALU result, shared by all requesters
// - rsp_zero        out  1            registered ALU zero flag
// - alu_instruction out  OP_W         to ALU instruction
// - alu_input1      out  WIDTH        to ALU input1
// - alu_input2      out  WIDTH        to ALU input2
// - alu_result      in   WIDTH        from ALU result
// - alu_zero        in   1            from ALU zero
// BEHAVIOUR
// - Reset (reset_n=0 at a posedge): state=IDLE; rr pointer=0; op/operand regs=0;
//   result reg=0; zero reg=0; req_ready=0; rsp_valid=0; alu_* outputs=0.
// - FSM states: IDLE, EXEC, RESP.
// - IDLE: grant = first i with req_valid[i], searching from the rr pointer upward with wrap.
//   req_ready[grant]=1 combinationally in IDLE only; all other req_ready bits are 0.
//   Accept at an edge where req_valid[g] & req_ready[g]: latch op/a/b and grant id -> EXEC;
//   rr pointer <= (g+1) mod N_REQ. No valid: stay in IDLE, pointer unchanged.
// - EXEC (exactly 1 cycle): alu_* driven from latched regs; at the end of the cycle,
//   capture alu_result/alu_zero into the result/zero regs -> RESP.
// - RESP: rsp_valid[grant]=1, rsp_result/rsp_zero stable. rsp_ready[grant]=1 -> IDLE.
//   rsp_ready on non-granted bits is ignored. Hold indefinitely under backpressure.
// - Latency: accept at edge T -> rsp_valid high in the cycle after edge T+2 (2 cycles);
//   with rsp_ready held at 1, the next accept occurs at edge T+4 at the earliest.
// - alu_* outputs always reflect the latched regs (stable in IDLE/RESP; only change on accept).
// - A requester's inputs may change freely after acceptance; the latched copy is used.
// - Requests arriving during EXEC/RESP wait (req_ready=0); no queueing inside the block.
// - Fairness: with all requesters continuously valid, grants rotate 0,1,..,N_REQ-1,0.
// - Opcodes are passed through unchanged; undefined opcodes (101,110,111) are not trapped;
//   the ALU response (8'hFF) is returned as-is.
// - Reset during EXEC or RESP: the in-flight op is dropped and no rsp_valid is issued;
//   all reset values apply from the next cycle.
// - Simultaneous rsp handshake in RESP and a new req_valid: the new request is accepted
//   no earlier than the following IDLE cycle.
// STRUCTURE
// - alu_pkg: localparams OP_XOR=3'b000, OP_BEQ=3'b001, OP_ADD=3'b010, OP_AND=3'b011,
//   OP_RSL=3'b100; WIDTH/OP_W constants; typedef enum {IDLE,EXEC,RESP} arb_state_t.
// - Sub-module rr_arbiter (N_REQ): req vector + pointer -> one-hot grant + index; pure comb.
// - The ALU is instantiated outside; this block only drives and samples its ports.
// TESTING (bench instantiates alu_arbiter + alu, N_REQ=2)
// - Req0 XOR a=8'hAA b=8'h55 -> req_ready[0] at accept, rsp_valid[0] 2 cycles later,
//   rsp_result=8'hFF, rsp_zero=0.
// - Req1 BEQ a=8'hFF b=8'hFF -> rsp_zero=1; then BEQ a=8'hAA b=8'h55 -> rsp_zero=0.
// - Both valid every cycle (req0 ADD 8'hFF+8'h02, req1 RSL 8'h91 by 3) -> grants alternate 0,1,0;
//   req0 gets 8'h01, req1 gets 8'h8C; rsp_valid never on the wrong requester.
// - Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid/rsp_result stable,
//   req_ready stays 0; release -> IDLE, next accept follows.
// - Undefined op 3'b110, a=8'h91 -> rsp_result=8'hFF passed through unchanged.
// - Assert reset_n=0 during EXEC and again during RESP -> no rsp_valid; all outputs 0
//   after the edge; a new request afterwards is granted to requester 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// - Opcode encodings understood by the downstream combinational ALU.
// - Datapath width constants used as parameter defaults.
// - Arbiter FSM state type and the round-robin pointer helper.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_OP_W  = 3;

  localparam logic [2:0] OP_XOR = 3'b000;
  localparam logic [2:0] OP_BEQ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_RSL = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } arb_state_t;

  // Index of the requester after idx, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    int nxt;
    if (idx + 1 >= n) begin
      nxt = 0;
    end else begin
      nxt = idx + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/alu_arbiter_chk.sv
// Protocol checker for alu_arbiter handshake outputs.
// Ports: clk, reset_n, and the request/response valid/ready vectors observed.
module alu_arbiter_chk #(
  parameter int N_REQ = 2
) (
  input logic             clk,
  input logic             reset_n,
  input logic [N_REQ-1:0] req_valid,
  input logic [N_REQ-1:0] req_ready,
  input logic [N_REQ-1:0] rsp_valid
);

  a_req_ready_onehot0 : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(req_ready));

  a_rsp_valid_onehot0 : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(rsp_valid));

  a_ready_needs_valid : assert property (@(posedge clk) disable iff (!reset_n)
    ((req_ready & ~req_valid) == '0));

  // A grant is only offered when no response is outstanding.
  a_no_accept_during_rsp : assert property (@(posedge clk) disable iff (!reset_n)
    (req_ready != '0) |-> (rsp_valid == '0));

endmodule

// File: rtl/alu_arbiter_rr.sv
// Round-robin priority picker (purely combinational).
// Ports:
//   req_i   [N_REQ-1:0]  request vector
//   ptr_i   [IDX_W-1:0]  highest-priority index this cycle
//   grant_o [N_REQ-1:0]  one-hot grant (all zero when nothing requests)
//   idx_o   [IDX_W-1:0]  index of the granted requester
//   found_o              at least one request present
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = 1
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             found_o
);

  // Scan from the pointer upward with wrap; the first requester seen wins.
  // The inner loop keeps every bit select constant.
  always_comb begin
    int cand;
    grant_o = '0;
    idx_o   = '0;
    found_o = 1'b0;
    cand    = 0;
    for (int off = 0; off < N_REQ; off++) begin
      if (int'(ptr_i) + off >= N_REQ) begin
        cand = int'(ptr_i) + off - N_REQ;
      end else begin
        cand = int'(ptr_i) + off;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!found_o && (i == cand) && req_i[i]) begin
          found_o    = 1'b1;
          grant_o[i] = 1'b1;
          idx_o      = IDX_W'(i);
        end else begin
          found_o = found_o;
        end
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between N_REQ requesters, one op in flight.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   req_valid/req_ready     per-requester request handshake
//   req_op/req_a/req_b      packed per-requester opcode and operands
//   rsp_valid/rsp_ready     per-requester response handshake
//   rsp_result/rsp_zero     registered ALU result and zero flag (shared)
//   alu_instruction/alu_input1/alu_input2   driven to the ALU from latched regs
//   alu_result/alu_zero     sampled from the ALU at the end of EXEC
// Flow: IDLE (round-robin grant) -> EXEC (one cycle, capture result) ->
// RESP (registered rsp_valid, held until the granted requester takes it).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int WIDTH = ALU_WIDTH,
  parameter int OP_W  = ALU_OP_W
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*OP_W-1:0]   req_op,
  input  logic [N_REQ*WIDTH-1:0]  req_a,
  input  logic [N_REQ*WIDTH-1:0]  req_b,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [WIDTH-1:0]        rsp_result,
  output logic                    rsp_zero,
  output logic [OP_W-1:0]         alu_instruction,
  output logic [WIDTH-1:0]        alu_input1,
  output logic [WIDTH-1:0]        alu_input2,
  input  logic [WIDTH-1:0]        alu_result,
  input  logic                    alu_zero
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [N_REQ-1:0] arb_grant_s;
  logic [IDX_W-1:0] arb_idx_s;
  logic             arb_found_s;
  logic [N_REQ-1:0] req_ready_s;
  logic [N_REQ-1:0] gnt_onehot_s;
  logic             req_fire_s;
  logic             rsp_fire_s;
  logic [OP_W-1:0]  op_sel_s;
  logic [WIDTH-1:0] a_sel_s;
  logic [WIDTH-1:0] b_sel_s;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i   (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant_s),
    .idx_o   (arb_idx_s),
    .found_o (arb_found_s)
  );

  // Grant is offered only in IDLE and never while reset is asserted.
  always_comb begin
    req_ready_s = '0;
    if ((state_q == IDLE) && reset_n && arb_found_s) begin
      req_ready_s = arb_grant_s;
    end else begin
      req_ready_s = '0;
    end
  end

  // Handshake qualifiers; rsp_valid_q is one-hot at the grant, so
  // rsp_ready bits of other requesters drop out of the AND.
  always_comb begin
    req_fire_s = |(req_valid & req_ready_s);
    rsp_fire_s = |(rsp_valid_q & rsp_ready);
  end

  // One-hot form of the latched grant index.
  always_comb begin
    gnt_onehot_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (int'(gnt_q) == i) begin
        gnt_onehot_s[i] = 1'b1;
      end else begin
        gnt_onehot_s[i] = 1'b0;
      end
    end
  end

  // Pick the granted requester's opcode and operands out of the packed buses.
  always_comb begin
    op_sel_s = '0;
    a_sel_s  = '0;
    b_sel_s  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (int'(arb_idx_s) == i) begin
        op_sel_s = req_op[i*OP_W +: OP_W];
        a_sel_s  = req_a[i*WIDTH +: WIDTH];
        b_sel_s  = req_b[i*WIDTH +: WIDTH];
      end else begin
        op_sel_s = op_sel_s;
        a_sel_s  = a_sel_s;
        b_sel_s  = b_sel_s;
      end
    end
  end

  // FSM next-state and datapath register updates.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    zero_d      = zero_q;
    rsp_valid_d = '0;
    case (state_q)
      IDLE: begin
        if (req_fire_s) begin
          state_d = EXEC;
          gnt_d   = arb_idx_s;
          op_d    = op_sel_s;
          a_d     = a_sel_s;
          b_d     = b_sel_s;
          ptr_d   = IDX_W'(rr_next(int'(arb_idx_s), N_REQ));
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        // ALU inputs have been stable from the latched regs all cycle.
        result_d = alu_result;
        zero_d   = alu_zero;
        state_d  = RESP;
      end
      RESP: begin
        // rsp_valid is registered, so it rises one cycle into RESP; the
        // handshake can only complete once it is visible.
        if (rsp_fire_s) begin
          state_d     = IDLE;
          rsp_valid_d = '0;
        end else begin
          state_d     = RESP;
          rsp_valid_d = gnt_onehot_s;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = '0;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready       = req_ready_s;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_result      = result_q;
  assign rsp_zero        = zero_q;
  assign alu_instruction = op_q;
  assign alu_input1      = a_q;
  assign alu_input2      = b_q;

  alu_arbiter_chk #(
    .N_REQ (N_REQ)
  ) u_chk (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready_s),
    .rsp_valid (rsp_valid_q)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [5:0]   req_op;
  logic [15:0]  req_a;
  logic [15:0]  req_b;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [7:0]   rsp_result;
  logic         rsp_zero;
  logic [2:0]   alu_instruction;
  logic [7:0]   alu_input1;
  logic [7:0]   alu_input2;
  logic [7:0]   alu_result;
  logic         alu_zero;

  always #5 clk = ~clk;

  alu_arbiter #(.N_REQ(N), .WIDTH(8), .OP_W(3)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_instruction(alu_instruction), .alu_input1(alu_input1),
    .alu_input2(alu_input2), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // Behavioural ALU: RSL rotates left by input2[2:0]; BEQ subtracts.
  always_comb begin
    logic [15:0] rot;
    rot = {alu_input1, alu_input1} << alu_input2[2:0];
    case (alu_instruction)
      OP_XOR:  alu_result = alu_input1 ^ alu_input2;
      OP_BEQ:  alu_result = alu_input1 - alu_input2;
      OP_ADD:  alu_result = alu_input1 + alu_input2;
      OP_AND:  alu_result = alu_input1 & alu_input2;
      OP_RSL:  alu_result = rot[15:8];
      default: alu_result = 8'hFF;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  typedef struct {
    int       id;
    logic [7:0] res;
    logic     zero;
    int       acc_cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         grant_q[$];
  int         acc_hist[$];
  logic [7:0] exp_res [2];
  logic       exp_zero[2];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         accepts = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Accept watcher: a handshake seen here completes at the next posedge.
  exp_t w_e;
  always @(negedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          w_e.id      = i;
          w_e.res     = exp_res[i];
          w_e.zero    = exp_zero[i];
          w_e.acc_cyc = cyc + 1;
          exp_q.push_back(w_e);
          grant_q.push_back(i);
          acc_hist.push_back(cyc + 1);
          accepts++;
        end
      end
    end
  end

  // Response monitor.
  logic [1:0] prev_vld = 2'b00;
  logic [7:0] prev_res;
  logic       prev_zero;
  int         rise_cyc = 0;
  exp_t       m_e;
  logic [1:0] m_oh;
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_vld = 2'b00;
    end else begin
      if (rsp_valid != 2'b00) begin
        chk("rsp_valid_onehot", $countones(rsp_valid), 1);
        if (req_valid != 2'b00) chk("req_ready_while_rsp", int'(req_ready), 0);
        if (prev_vld == 2'b00) begin
          rise_cyc = cyc;
        end else begin
          chk("rsp_valid_stable", int'(rsp_valid), int'(prev_vld));
          chk("rsp_result_stable", int'(rsp_result), int'(prev_res));
          chk("rsp_zero_stable", int'(rsp_zero), int'(prev_zero));
        end
        if ((rsp_valid & rsp_ready) != 2'b00) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", exp_q.size(), 1);
          end else begin
            m_e  = exp_q.pop_front();
            m_oh = 2'b01 << m_e.id;
            chk("rsp_id", int'(rsp_valid), int'(m_oh));
            chk("rsp_result", int'(rsp_result), int'(m_e.res));
            chk("rsp_zero", int'(rsp_zero), int'(m_e.zero));
            chk("rsp_latency", rise_cyc - m_e.acc_cyc, 2);
          end
        end
      end
      prev_vld  = rsp_valid;
      prev_res  = rsp_result;
      prev_zero = rsp_zero;
    end
  end

  task automatic set_req(input int id, input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] er, input logic ez);
    req_op[id*3 +: 3] = op;
    req_a[id*8 +: 8]  = a;
    req_b[id*8 +: 8]  = b;
    exp_res[id]       = er;
    exp_zero[id]      = ez;
    req_valid[id]     = 1'b1;
  endtask

  task automatic wait_accepts(input int target, input string name);
    int k = 0;
    while (accepts < target && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_accepted"}, int'(accepts >= target), 1);
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_rsp(input string name);
    int k = 0;
    while (rsp_valid == 2'b00 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk({name, "_rsp_seen"}, int'(rsp_valid != 2'b00), 1);
  endtask

  task automatic chk_zero_outputs(input string name);
    chk({name, "_req_ready"}, int'(req_ready), 0);
    chk({name, "_rsp_valid"}, int'(rsp_valid), 0);
    chk({name, "_rsp_result"}, int'(rsp_result), 0);
    chk({name, "_rsp_zero"}, int'(rsp_zero), 0);
    chk({name, "_alu_instr"}, int'(alu_instruction), 0);
    chk({name, "_alu_in1"}, int'(alu_input1), 0);
    chk({name, "_alu_in2"}, int'(alu_input2), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int a_before;
    reset_n   = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    req_op    = 6'h00;
    req_a     = 16'h0000;
    req_b     = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    reset_n   = 1'b1;
    rsp_ready = 2'b11;
    @(posedge clk); #1;

    // Req0 XOR; operands changed after acceptance must not matter.
    set_req(0, OP_XOR, 8'hAA, 8'h55, 8'hFF, 1'b0);
    wait_accepts(accepts + 1, "xor");
    req_valid[0] = 1'b0;
    req_a[7:0]   = 8'h00;
    req_b[7:0]   = 8'h00;
    chk("xor_alu_instr", int'(alu_instruction), int'(OP_XOR));
    chk("xor_alu_in1", int'(alu_input1), 32'hAA);
    chk("xor_alu_in2", int'(alu_input2), 32'h55);
    drain("xor");

    // Req1 BEQ equal then unequal.
    set_req(1, OP_BEQ, 8'hFF, 8'hFF, 8'h00, 1'b1);
    wait_accepts(accepts + 1, "beq_eq");
    req_valid[1] = 1'b0;
    drain("beq_eq");
    set_req(1, OP_BEQ, 8'hAA, 8'h55, 8'h55, 1'b0);
    wait_accepts(accepts + 1, "beq_ne");
    req_valid[1] = 1'b0;
    drain("beq_ne");

    // Both continuously valid: grants must go 0,1,0, four edges apart.
    g = grant_q.size();
    set_req(0, OP_ADD, 8'hFF, 8'h02, 8'h01, 1'b0);
    set_req(1, OP_RSL, 8'h91, 8'h03, 8'h8C, 1'b0);
    wait_accepts(accepts + 3, "rr");
    req_valid = 2'b00;
    drain("rr");
    chk("rr_grant0", grant_q[g], 0);
    chk("rr_grant1", grant_q[g+1], 1);
    chk("rr_grant2", grant_q[g+2], 0);
    chk("rr_spacing", acc_hist[g+1] - acc_hist[g], 4);

    // Backpressure: only the non-granted ready bit is high for 10 cycles.
    rsp_ready = 2'b10;
    set_req(0, OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0);
    wait_accepts(accepts + 1, "bp");
    req_valid[0] = 1'b0;
    set_req(1, OP_XOR, 8'h0F, 8'h0F, 8'h00, 1'b1);
    wait_rsp("bp");
    a_before = accepts;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_no_accept", accepts, a_before);
    chk("bp_rsp_held", int'(rsp_valid), 32'h1);
    rsp_ready = 2'b11;
    wait_accepts(a_before + 1, "bp_next");
    req_valid[1] = 1'b0;
    drain("bp");

    // Undefined opcode passes the ALU response through.
    set_req(0, 3'b110, 8'h91, 8'h00, 8'hFF, 1'b0);
    wait_accepts(accepts + 1, "undef");
    req_valid[0] = 1'b0;
    drain("undef");

    // Reset while in EXEC.
    set_req(0, OP_ADD, 8'h01, 8'h01, 8'h02, 1'b0);
    wait_accepts(accepts + 1, "rst_exec");
    req_valid = 2'b00;
    reset_n   = 1'b0;
    @(posedge clk); #1;
    chk_zero_outputs("rst_exec");
    exp_q.delete();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_exec_no_rsp", int'(rsp_valid), 0);
    end

    // Reset while in RESP.
    rsp_ready = 2'b00;
    set_req(1, OP_XOR, 8'h12, 8'h34, 8'h26, 1'b0);
    wait_accepts(accepts + 1, "rst_resp");
    req_valid = 2'b00;
    wait_rsp("rst_resp");
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_zero_outputs("rst_resp");
    exp_q.delete();
    reset_n   = 1'b1;
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_resp_no_rsp", int'(rsp_valid), 0);
    end

    // After reset the pointer is back at requester 0.
    g = grant_q.size();
    set_req(0, OP_XOR, 8'h0F, 8'hF0, 8'hFF, 1'b0);
    set_req(1, OP_AND, 8'hFF, 8'h0F, 8'h0F, 1'b0);
    wait_accepts(accepts + 1, "post_rst");
    req_valid = 2'b00;
    drain("post_rst");
    chk("post_rst_grant", grant_q[g], 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
